// File: rtl/lib_arb_mux_rr.sv
// Round-robin arbitrating mux with a registered output stage (valid/ready streams).
// Optional packet lock (hold grant until last_i) enabled by defining LIB_ARB_MUX_RR_PKT_LOCK_EN.
module lib_arb_mux_rr #(
    parameter int unsigned PORTS_NUMBER = 4,
    parameter int unsigned WIDTH        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PORTS_NUMBER-1:0] valid_i,
    input  logic [WIDTH-1:0]        data_i [PORTS_NUMBER],
    input  logic [PORTS_NUMBER-1:0] last_i,
    output logic [PORTS_NUMBER-1:0] ready_o,
    output logic                    valid_o,
    output logic [WIDTH-1:0]        data_o,
    output logic                    last_o,
    output logic [PORTS_NUMBER-1:0] grant_o,
    input  logic                    ready_i
);

    localparam int unsigned N = PORTS_NUMBER;

    logic [N-1:0]     r_base;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic [N-1:0]     r_grant;

    logic [N-1:0]     w_base_mask;
    logic [N-1:0]     w_hi;
    logic [N-1:0]     w_arb_sel;
    logic [N-1:0]     w_sel;
    logic [N-1:0]     w_sel_rot;
    logic [N-1:0]     w_ready;
    logic             w_accept;
    logic             w_xfer;
    logic             w_last_sel;
    logic [WIDTH-1:0] w_data_sel;

    assign w_accept = !r_valid || ready_i;

    // Bits at or above the one-hot base; lowest set bit of the masked request wins,
    // otherwise wrap around to the lowest set bit of the whole request vector.
    assign w_base_mask = ~(r_base - N'(1));
    assign w_hi        = valid_i & w_base_mask;
    assign w_arb_sel   = (|w_hi) ? (w_hi & (~w_hi + N'(1)))
                                 : (valid_i & (~valid_i + N'(1)));

`ifdef LIB_ARB_MUX_RR_PKT_LOCK_EN
    logic         r_lock;
    logic [N-1:0] r_lock_sel;

    assign w_sel = r_lock ? (r_lock_sel & valid_i) : w_arb_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock     <= 1'b0;
            r_lock_sel <= '0;
        end else if (w_xfer) begin
            r_lock <= !w_last_sel;
            if (!w_last_sel) begin
                r_lock_sel <= w_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= N'(1);
        end else if (w_xfer && w_last_sel) begin
            r_base <= w_sel_rot;
        end
    end
`else
    assign w_sel = w_arb_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= N'(1);
        end else if (w_xfer) begin
            r_base <= w_sel_rot;
        end
    end
`endif

    assign w_ready   = w_accept ? w_sel : '0;
    assign w_xfer    = |w_ready;
    assign w_sel_rot = (w_sel << 1) | (w_sel >> (N - 1));

    always_comb begin
        w_data_sel = '0;
        w_last_sel = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_sel[i]) begin
                w_data_sel = w_data_sel | data_i[i];
                w_last_sel = w_last_sel | last_i[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_grant <= '0;
        end else if (w_accept) begin
            if (w_xfer) begin
                r_valid <= 1'b1;
                r_data  <= w_data_sel;
                r_last  <= w_last_sel;
                r_grant <= w_sel;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign ready_o = w_ready;
    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign last_o  = r_last;
    assign grant_o = r_grant;

endmodule

// File: tb/tb_lib_arb_mux_rr.sv
// Bench for lib_arb_mux_rr: directed scenarios plus randomized traffic against a
// port-index reference model (round-robin search by modular arithmetic).
module tb_lib_arb_mux_rr;

    localparam int N = 4;
    localparam int W = 8;
`ifdef LIB_ARB_MUX_RR_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] valid_i = '0;
    logic [W-1:0] data_i [N];
    logic [N-1:0] last_i = '0;
    logic [N-1:0] ready_o;
    logic         valid_o;
    logic [W-1:0] data_o;
    logic         last_o;
    logic [N-1:0] grant_o;
    logic         ready_i = 1'b1;

    lib_arb_mux_rr #(.PORTS_NUMBER(N), .WIDTH(W)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .data_i  (data_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .last_o  (last_o),
        .grant_o (grant_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    // Upstream must hold a request until it is accepted.
    for (genvar g = 0; g < N; g++) begin : g_hold
        assert property (@(posedge clk) disable iff (rst)
                         valid_i[g] && !ready_o[g] |=> valid_i[g]);
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: port numbers, -1 meaning none.
    bit       m_valid;
    bit       m_last;
    bit [W-1:0] m_data;
    int       m_grant;
    int       m_base;
    bit       m_lock;
    int       m_lock_port;
    int       last_xfer;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int p);
        logic [N-1:0] v;
        v = '0;
        if (p >= 0) v[p] = 1'b1;
        return v;
    endfunction

    function automatic int pick();
        int p;
        if (LOCK && m_lock) return valid_i[m_lock_port] ? m_lock_port : -1;
        for (int k = 0; k < N; k++) begin
            p = (m_base + k) % N;
            if (valid_i[p]) return p;
        end
        return -1;
    endfunction

    // One clock: check ready_o for the applied inputs, advance the model, check outputs.
    task automatic cycle();
        int  p;
        bit  acc;
        #1;
        p   = pick();
        acc = !m_valid || ready_i;
        check_eq("ready_o", 32'(ready_o), 32'((acc && p >= 0) ? onehot(p) : '0));
        last_xfer = -1;
        if (rst) begin
            m_valid = 0; m_data = '0; m_last = 0; m_grant = -1;
            m_base = 0; m_lock = 0; m_lock_port = 0;
        end else if (acc) begin
            if (p >= 0) begin
                last_xfer = p;
                m_valid = 1; m_data = data_i[p]; m_last = last_i[p]; m_grant = p;
                if (LOCK && !last_i[p]) begin
                    m_lock = 1; m_lock_port = p;
                end else begin
                    m_lock = 0; m_base = (p + 1) % N;
                end
            end else begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        check_eq("valid_o", 32'(valid_o), 32'(m_valid));
        check_eq("grant_o", 32'(grant_o), 32'(onehot(m_grant)));
        check_eq("data_o",  32'(data_o),  32'(m_data));
        check_eq("last_o",  32'(last_o),  32'(m_last));
    endtask

    bit         pend [N];
    logic [W-1:0] pdata [N];
    bit         plast [N];

    initial begin
        for (int i = 0; i < N; i++) data_i[i] = '0;
        m_grant = -1;
        // Reset, then idle
        rst = 1'b1; cycle();
        rst = 1'b0;
        repeat (3) cycle();
        // Fairness with all ports requesting; ends with base at port 2
        for (int i = 0; i < N; i++) data_i[i] = W'(8'h11 * i);
        last_i = '1; valid_i = '1;
        repeat (6) cycle();
        // Reset with a beat in flight
        rst = 1'b1; cycle();
        rst = 1'b0;
        // Wrap-around: port 1 then {0,1} -> port 0
        valid_i = 4'b0010; cycle();
        valid_i = 4'b0011; cycle();
        valid_i = 4'b0010; cycle();
        // Port 3 beat then backpressure with 0101 pending
        valid_i = 4'b1000; cycle();
        valid_i = 4'b0101; ready_i = 1'b0;
        repeat (4) cycle();
        ready_i = 1'b1; cycle();
        valid_i = 4'b0100; cycle();
        valid_i = 4'b0000; repeat (2) cycle();
        // Randomized traffic
        rst = 1'b1; cycle();
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1;
                    pdata[i] = W'($urandom);
                    plast[i] = 1'($urandom_range(0, 1));
                end
                valid_i[i] = pend[i];
                data_i[i]  = pdata[i];
                last_i[i]  = plast[i];
            end
            ready_i = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 299) == 0);
            cycle();
            if (rst) begin
                for (int i = 0; i < N; i++) pend[i] = 0;
            end else if (last_xfer >= 0) begin
                pend[last_xfer] = 0;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
